dma_chan_sched: RTL and testbench

- Round-robin burst scheduler that shares the single DMA transfer datapath inside tt_um_dma among NUM_CH request channels.
- Accepts per-channel jobs (beat count) and grants the datapath to one channel at a time for up to BURST beats.
- Drives a valid/ready beat interface to the datapath and reports per-channel accept and completion pulses.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_rr_pick.sv | 32 +++
 rtl/dma_chan_sched.sv | 122 ++++++++++++
 tb/tb_dma_chan_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel scheduler: FSM state encoding,
// index-width helper and default parameter values.
package dma_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_BURST  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Width of a channel index; never below one bit so ports stay legal.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or above ptr,
// wrapping at NUM_CH.
module dma_rr_pick
  import dma_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NUM_CH;
  endfunction

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan from the farthest offset down so the nearest pending channel wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending[wrap_idx(int'(ptr), k)]) begin
        valid = 1'b1;
        idx   = CH_W'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin burst scheduler sharing one DMA beat datapath among NUM_CH channels.
// Optional macro DMA_CH0_PRIO_EN: channel 0 wins every burst-boundary arbitration.
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int LEN_W  = DEF_LEN_W,
  parameter  int BURST  = DEF_BURST,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  output logic [NUM_CH-1:0]       ch_ack,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    xfer_valid,
  output logic [CH_W-1:0]         xfer_ch,
  output logic                    xfer_last,
  input  logic                    xfer_ready,
  output logic                    busy
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q [NUM_CH];
  logic [LEN_W-1:0]  burst_q;
  logic [CH_W-1:0]   ptr_q, ch_q;
  logic [NUM_CH-1:0] ack_q, done_q;

  logic [NUM_CH-1:0] pending, accept, zero_len, last_hit;
  logic              pick_valid, prio_hit, beat, cur_last;
  logic [CH_W-1:0]   pick_idx, grant_idx, ptr_next;

  dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .pending (pending),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  assign beat     = (state_q == XFER) && xfer_ready;
  assign cur_last = (rem_q[ch_q] == LEN_W'(1));

`ifdef DMA_CH0_PRIO_EN
  assign prio_hit = pending[0];
`else
  assign prio_hit = 1'b0;
`endif

  assign grant_idx = prio_hit ? '0 : pick_idx;
  assign ptr_next  = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_W'(1);

  always_comb begin
    pending  = '0;
    accept   = '0;
    zero_len = '0;
    last_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pending[i]  = (rem_q[i] != '0);
      accept[i]   = ch_req[i] && (rem_q[i] == '0) &&
                    !((state_q == XFER) && (ch_q == CH_W'(i)));
      zero_len[i] = accept[i] && (ch_len[i*LEN_W +: LEN_W] == '0);
      last_hit[i] = beat && cur_last && (ch_q == CH_W'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = XFER;
      XFER:    if (beat && (cur_last || burst_q == LEN_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the remaining-beat array is reset explicitly; jobs in flight at reset
  // must vanish, so it cannot be left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) rem_q[i] <= '0;
      burst_q <= '0;
      ptr_q   <= '0;
      ch_q    <= '0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      ack_q  <= accept;
      done_q <= zero_len | last_hit;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i])
          rem_q[i] <= ch_len[i*LEN_W +: LEN_W];
        else if (beat && ch_q == CH_W'(i))
          rem_q[i] <= rem_q[i] - LEN_W'(1);
      end
      if (state_q == IDLE && pick_valid) begin
        ch_q    <= grant_idx;
        burst_q <= LEN_W'(BURST);
        // A priority grant to channel 0 leaves the rotation untouched.
        if (!prio_hit) ptr_q <= ptr_next;
      end else if (beat) begin
        burst_q <= burst_q - LEN_W'(1);
      end
    end
  end

  always_comb begin
    xfer_valid = (state_q == XFER);
    xfer_last  = (state_q == XFER) && cur_last;
    xfer_ch    = ch_q;
    ch_ack     = ack_q;
    ch_done    = done_q;
    busy       = (state_q == XFER) || (|pending);
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Self-checking bench for dma_chan_sched: job-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dma_chan_sched;

  localparam int NUM_CH = 4;
  localparam int LEN_W  = 8;
  localparam int BURST  = 4;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       ch_req = '0;
  logic [NUM_CH*LEN_W-1:0] ch_len = '0;
  logic [NUM_CH-1:0]       ch_ack, ch_done;
  logic                    xfer_valid, xfer_last, busy;
  logic [CH_W-1:0]         xfer_ch;
  logic                    xfer_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  dma_chan_sched #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_req     (ch_req),
    .ch_len     (ch_len),
    .ch_ack     (ch_ack),
    .ch_done    (ch_done),
    .xfer_valid (xfer_valid),
    .xfer_ch    (xfer_ch),
    .xfer_last  (xfer_last),
    .xfer_ready (xfer_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level reference model ----------------
  int          m_rem [NUM_CH];
  int          m_g;      // granted channel, -1 between bursts
  int          m_ch;     // last granted channel
  int          m_left;   // beats left in current burst
  int          m_ptr;
  logic [NUM_CH-1:0] m_ack, m_done;

  task automatic model_step();
    int old_rem [NUM_CH];
    logic [NUM_CH-1:0] acc, dn;
    int w;
    old_rem = m_rem;
    acc = '0;
    dn  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i] = ch_req[i] && old_rem[i] == 0 && m_g != i;
      dn[i]  = acc[i] && ch_len[i*LEN_W +: LEN_W] == 0;
    end
    if (m_g >= 0) begin
      if (xfer_ready) begin
        if (old_rem[m_g] == 1) dn[m_g] = 1'b1;
        m_rem[m_g] = m_rem[m_g] - 1;
        m_left = m_left - 1;
        if (old_rem[m_g] == 1 || m_left == 0) m_g = -1;
      end
    end else begin
      w = -1;
`ifdef DMA_CH0_PRIO_EN
      if (old_rem[0] > 0) w = 0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        if (w < 0 && old_rem[(m_ptr + k) % NUM_CH] > 0) begin
          w = (m_ptr + k) % NUM_CH;
          m_ptr = (w + 1) % NUM_CH;
        end
      end
      if (w >= 0) begin
        m_g = w;
        m_ch = w;
        m_left = BURST;
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (acc[i]) m_rem[i] = int'(ch_len[i*LEN_W +: LEN_W]);
    m_ack  = acc;
    m_done = dn;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
      m_g = -1; m_ch = 0; m_left = 0; m_ptr = 0;
      m_ack = '0; m_done = '0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare and event logging ----------------
  int hs_log [$];
  int hs_cyc [$];
  int done_cnt [NUM_CH];
  int valid_cyc;
  int cyc = 0;
  int busy_any;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      check("xfer_valid", xfer_valid, m_g >= 0);
      if (m_g >= 0) check("xfer_ch", xfer_ch, m_ch);
      check("xfer_last", xfer_last, (m_g >= 0) ? (m_rem[m_g] == 1) : 0);
      busy_any = (m_g >= 0);
      for (int i = 0; i < NUM_CH; i++) if (m_rem[i] != 0) busy_any = 1;
      check("busy", busy, busy_any);
      check("ch_ack", ch_ack, m_ack);
      check("ch_done", ch_done, m_done);
      if (xfer_valid && xfer_ready) begin
        hs_log.push_back(int'(xfer_ch));
        hs_cyc.push_back(cyc);
      end
      for (int i = 0; i < NUM_CH; i++) done_cnt[i] += int'(ch_done[i]);
      valid_cyc += int'(xfer_valid);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_log.delete();
    hs_cyc.delete();
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    valid_cyc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, xfer_valid, 0);
    check({tag, "_last"}, xfer_last, 0);
    check({tag, "_ch"}, xfer_ch, 0);
    check({tag, "_ack"}, ch_ack, 0);
    check({tag, "_done"}, ch_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    ch_req = '0;
    xfer_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic set_job(input int ch, input int len);
    ch_req[ch] = 1'b1;
    ch_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("drain_busy", busy, 0);
    tick();
    tick();
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_count"}, hs_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < hs_log.size(); k++)
      check(name, hs_log[k], exp[k]);
  endtask

  // ---------------- main flow ----------------
  initial begin
    int exp_q[$];
    int k;
    clear_logs();
    #3 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: single channel, len=3
    do_reset();
    set_job(1, 3);
    tick();
    check("t1_ack", ch_ack, 4'b0010);
    check("t1_valid0", xfer_valid, 0);
    ch_req = '0;
    tick();
    check("t1_valid", xfer_valid, 1);
    check("t1_ch", xfer_ch, 1);
    check("t1_last0", xfer_last, 0);
    tick();
    tick();
    check("t1_last", xfer_last, 1);
    tick();
    check("t1_done", ch_done, 4'b0010);
    check("t1_valid_end", xfer_valid, 0);
    check("t1_busy", busy, 0);
    tick();
    exp_q = '{1, 1, 1};
    check_seq("t1_seq", exp_q);

    // T2: ch0 len=6 and ch2 len=2 together
    do_reset();
    set_job(0, 6);
    set_job(2, 2);
    tick();
    ch_req = '0;
    wait_idle(100);
`ifdef DMA_CH0_PRIO_EN
    exp_q = '{0, 0, 0, 0, 0, 0, 2, 2};
`else
    exp_q = '{0, 0, 0, 0, 2, 2, 0, 0};
`endif
    check_seq("t2_seq", exp_q);
    if (hs_cyc.size() == 8) check("t2_span", hs_cyc[7] - hs_cyc[0] + 1, 10);
    check("t2_done0", done_cnt[0], 1);
    check("t2_done2", done_cnt[2], 1);

    // T3: ch3 len=4 with a 5-cycle stall after beat 2
    do_reset();
    set_job(3, 4);
    tick();
    ch_req = '0;
    tick();
    tick();
    tick();
    xfer_ready = 1'b0;
    repeat (5) begin
      tick();
      check("t3_hold_valid", xfer_valid, 1);
      check("t3_hold_ch", xfer_ch, 3);
      check("t3_hold_last", xfer_last, 0);
    end
    xfer_ready = 1'b1;
    wait_idle(100);
    exp_q = '{3, 3, 3, 3};
    check_seq("t3_seq", exp_q);
    check("t3_done3", done_cnt[3], 1);

    // T4: zero-length job
    do_reset();
    set_job(2, 0);
    tick();
    check("t4_ack", ch_ack, 4'b0100);
    check("t4_done", ch_done, 4'b0100);
    ch_req = '0;
    repeat (3) tick();
    check("t4_nvalid", valid_cyc, 0);
    check("t4_busy", busy, 0);

    // T5: async reset mid-burst
    do_reset();
    set_job(1, 10);
    tick();
    ch_req = '0;
    k = 0;
    while (hs_log.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    check("t5_beats_seen", hs_log.size(), 3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_busy_after", busy, 0);
    check("t5_no_done", done_cnt[1], 0);
    clear_logs();
    set_job(1, 2);
    tick();
    ch_req = '0;
    wait_idle(100);
    exp_q = '{1, 1};
    check_seq("t5_seq", exp_q);
    check("t5_done1", done_cnt[1], 1);

    // T6: ch0 len=8 vs ch1 len=4
    do_reset();
    set_job(0, 8);
    set_job(1, 4);
    tick();
    ch_req = '0;
    wait_idle(100);
`ifdef DMA_CH0_PRIO_EN
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
    check_seq("t6_seq", exp_q);

    // T7: randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_req[i]) begin
          if (ch_ack[i] && $urandom_range(1, 0) == 1) ch_req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          set_job(i, $urandom_range(9, 0));
        end
      end
      xfer_ready = ($urandom_range(9, 0) < 7);
    end
    ch_req = '0;
    xfer_ready = 1'b1;
    tick();
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
